// File: rtl/light_show_sequencer.sv
// light_show_sequencer
//   Starts each attached light-pattern module in turn. It sends a go pulse,
//   waits for that pattern's finished signal, holds all lights off for a
//   gap, then moves on to the next pattern. A watchdog forces the advance
//   when a pattern never reports finished, and it records this in a sticky
//   error flag.
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active-high
//   enable         run the sequence while high
//   finished_in    per-pattern finished (a single-cycle pulse is enough)
//   pattern_lights pattern k drives bits [8k+7:8k]
//   go_out         one-hot, one-cycle go pulse to pattern k
//   lights         LED drive (the active pattern's lights while it runs)
//   active_idx     index of the current or next pattern
//   busy           high while launching, running or in the gap
//   timeout_err    sticky; set when any pattern times out
//   pattern_count  number of completed patterns (finished or timed out), wraps
module light_show_sequencer #(
    parameter int NUM_PATTERNS = 4,
    parameter int CLKS_PER_MS  = 50000,
    parameter int TIMEOUT_MS   = 30000,
    parameter int GAP_MS       = 500
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [NUM_PATTERNS-1:0]         finished_in,
    input  logic [8*NUM_PATTERNS-1:0]       pattern_lights,
    output logic [NUM_PATTERNS-1:0]         go_out,
    output logic [7:0]                      lights,
    output logic [$clog2(NUM_PATTERNS)-1:0] active_idx,
    output logic                            busy,
    output logic                            timeout_err,
    output logic [7:0]                      pattern_count
);

    localparam int IDX_W = $clog2(NUM_PATTERNS);
    localparam int PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    localparam logic [PRE_W-1:0]        PRE_LAST    = PRE_W'(CLKS_PER_MS - 1);
    localparam logic [15:0]             TIMEOUT_VAL = 16'(TIMEOUT_MS);
    localparam logic [15:0]             GAP_VAL     = 16'(GAP_MS);
    localparam logic [IDX_W-1:0]        IDX_LAST    = IDX_W'(NUM_PATTERNS - 1);
    localparam logic [NUM_PATTERNS-1:0] GO_ONE      = NUM_PATTERNS'(1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        GAP
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] prescaler;
    logic [15:0]      ms_timer;

    logic             ms_tick;
    logic             active_finished;
    logic [7:0]       active_lights;
    logic [IDX_W-1:0] next_idx;

    assign ms_tick         = (prescaler == PRE_LAST);
    assign active_finished = finished_in[active_idx];
    assign active_lights   = pattern_lights[{active_idx, 3'b000} +: 8];
    assign next_idx        = (active_idx == IDX_LAST) ? '0 : active_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            prescaler     <= '0;
            ms_timer      <= '0;
            go_out        <= '0;
            lights        <= '0;
            active_idx    <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            pattern_count <= '0;
        end else begin
            // NOTE: every assignment here is non-blocking, so an assignment
            // further down the same block overrides the defaults below.
            go_out <= '0;

            // Free-running ms timebase. The timer saturates so that a long
            // wait can never wrap back to a small value.
            if (ms_tick) begin
                prescaler <= '0;
                if (ms_timer != 16'hFFFF) begin
                    ms_timer <= ms_timer + 16'd1;
                end
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            case (state)
                IDLE: begin
                    lights <= '0;
                    if (enable) begin
                        state <= LAUNCH;
                        busy  <= 1'b1;
                    end
                end

                LAUNCH: begin
                    lights    <= '0;
                    go_out    <= GO_ONE << active_idx;
                    state     <= WAIT;
                    prescaler <= '0;
                    ms_timer  <= '0;
                end

                WAIT: begin
                    lights <= active_lights;
                    // Finished is checked first, so it wins over a timeout
                    // that occurs in the same cycle.
                    if (active_finished || ms_timer == TIMEOUT_VAL) begin
                        if (!active_finished) begin
                            timeout_err <= 1'b1;
                        end
                        pattern_count <= pattern_count + 8'd1;
                        lights        <= '0;
                        state         <= GAP;
                        prescaler     <= '0;
                        ms_timer      <= '0;
                    end
                end

                GAP: begin
                    lights <= '0;
                    if (ms_timer == GAP_VAL) begin
                        active_idx <= next_idx;
                        if (enable) begin
                            state <= LAUNCH;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_show_sequencer.sv
// Testbench for light_show_sequencer.
// The reference is a timeline model. A pattern's go pulse marks cycle 0 of
// its run. The pattern ends at cycle m = min(finish offset, TIMEOUT cycles),
// and its lights show from cycle 1 to cycle m. Then comes a gap of
// GAP_MS*CLKS_PER_MS+1 cycles and a launch cycle, so the next go arrives at
// cycle m+11.
module tb_light_show_sequencer;

    localparam int N     = 3;
    localparam int CPM   = 4;
    localparam int TMS   = 10;
    localparam int GMS   = 2;
    localparam int T_CYC = TMS * CPM;
    localparam int G_CYC = GMS * CPM;
    localparam int NEVER = 1000;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N-1:0]   finished_in;
    logic [8*N-1:0] pattern_lights;
    logic [N-1:0]   go_out;
    logic [7:0]     lights;
    logic [1:0]     active_idx;
    logic           busy;
    logic           timeout_err;
    logic [7:0]     pattern_count;

    int   n_checks = 0;
    int   n_fails  = 0;

    int   m_idx;
    int   m_count;
    logic m_te;

    light_show_sequencer #(
        .NUM_PATTERNS(N),
        .CLKS_PER_MS (CPM),
        .TIMEOUT_MS  (TMS),
        .GAP_MS      (GMS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .finished_in   (finished_in),
        .pattern_lights(pattern_lights),
        .go_out        (go_out),
        .lights        (lights),
        .active_idx    (active_idx),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .pattern_count (pattern_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " go_out"},        32'(go_out),        32'd0);
        check({tag, " lights"},        32'(lights),        32'd0);
        check({tag, " active_idx"},    32'(active_idx),    32'd0);
        check({tag, " busy"},          32'(busy),          32'd0);
        check({tag, " timeout_err"},   32'(timeout_err),   32'd0);
        check({tag, " pattern_count"}, 32'(pattern_count), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " go_out"},     32'(go_out),     32'd0);
        check({tag, " lights"},     32'(lights),     32'd0);
        check({tag, " busy"},       32'(busy),       32'd0);
        check({tag, " active_idx"}, 32'(active_idx), 32'(m_idx));
    endtask

    // The sequencer is idle and enable is raised. Expect one LAUNCH cycle,
    // then return on the cycle where the go pulse should be visible.
    task automatic start_run();
        finished_in = '0;
        enable      = 1'b1;
        step();
        check("launch busy",   32'(busy),   32'd1);
        check("launch go_out", 32'(go_out), 32'd0);
        check("launch lights", 32'(lights), 32'd0);
        step();
    endtask

    // Run one pattern starting at its go cycle.
    //   d       cycle offset (from go) at which the pattern asserts finished
    //   rnd     randomize light values and non-active finished noise
    //   spur    pulse a non-active finished bit early in the run
    //   stale   pulse the next pattern's finished bit during its launch cycle
    //   drop_at cycle at which enable is dropped (-1: never)
    //   rst_at  cycle at which reset is pulsed (-1: never)
    task automatic serve(input int d, input bit rnd, input bit spur, input bit stale,
                         input int drop_at, input int rst_at);
        int         m;
        int         nidx;
        int         k;
        bit         timed_out;
        bit         launch_next;
        bit         done;
        bit         aborted;
        logic [7:0] cur_slice;
        m           = (d > T_CYC) ? T_CYC : d;
        timed_out   = (d > T_CYC);
        nidx        = (m_idx + 1) % N;
        launch_next = 1'b0;
        done        = 1'b0;
        aborted     = 1'b0;
        cur_slice   = '0;
        k           = 0;
        while (!done) begin
            if (k == m + 11) begin
                done = 1'b1;
            end else begin
                check("go_out", 32'(go_out), (k == 0) ? 32'(1 << m_idx) : 32'd0);
                check("lights", 32'(lights), (k >= 1 && k <= m) ? 32'(cur_slice) : 32'd0);
                check("busy", 32'(busy), (k == m + 10 && !launch_next) ? 32'd0 : 32'd1);
                check("active_idx", 32'(active_idx), (k >= m + 10) ? 32'(nidx) : 32'(m_idx));
                check("pattern_count", 32'(pattern_count),
                      (k > m) ? 32'((m_count + 1) % 256) : 32'(m_count));
                check("timeout_err", 32'(timeout_err),
                      (k > m) ? 32'(m_te | timed_out) : 32'(m_te));
                if (k == m + 10 && !launch_next) begin
                    done = 1'b1;
                end else if (k == rst_at) begin
                    rst    = 1'b1;
                    enable = 1'b0;
                    #1;
                    check_reset_values("async reset");
                    step();
                    check_reset_values("held reset");
                    rst     = 1'b0;
                    aborted = 1'b1;
                    done    = 1'b1;
                end else begin
                    if (rnd) begin
                        pattern_lights = 24'($urandom());
                        finished_in    = N'($urandom());
                    end else begin
                        finished_in = '0;
                    end
                    cur_slice = 8'(pattern_lights >> (8 * m_idx));
                    if (k <= m) begin
                        if (k == d) finished_in = finished_in | N'(1 << m_idx);
                        else        finished_in = finished_in & ~N'(1 << m_idx);
                    end
                    if (spur && k == 3) finished_in = finished_in | N'(1 << ((m_idx + N - 1) % N));
                    if (stale && k == m + 10) finished_in = finished_in | N'(1 << nidx);
                    if (k == drop_at) enable = 1'b0;
                    if (k == m + 9) launch_next = enable;
                    step();
                    k++;
                end
            end
        end
        if (aborted) begin
            m_idx   = 0;
            m_count = 0;
            m_te    = 1'b0;
        end else begin
            m_count = (m_count + 1) % 256;
            m_te    = m_te | timed_out;
            m_idx   = nidx;
        end
    endtask

    initial begin
        int guard;
        rst            = 1'b0;
        enable         = 1'b0;
        finished_in    = '0;
        pattern_lights = {8'h33, 8'h22, 8'h11};
        m_idx          = 0;
        m_count        = 0;
        m_te           = 1'b0;

        // Reset, then stay idle with enable low.
        #2 rst = 1'b1;
        #1 check_reset_values("reset");
        step();
        step();
        check_reset_values("reset clocked");
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check_idle("idle");
        end

        // Normal rotation: each pattern finishes 5 ms after its go.
        start_run();
        serve(5 * CPM, 1'b0, 1'b0, 1'b0, -1, -1);
        serve(5 * CPM, 1'b0, 1'b0, 1'b0, -1, -1);
        serve(5 * CPM, 1'b0, 1'b0, 1'b0, -1, -1);
        check("lap pattern_count", 32'(pattern_count), 32'd3);
        check("lap gap covers", 32'(G_CYC + 3), 32'(dut.GAP_VAL * CPM + 3));

        // Finished on the exact timeout cycle of pattern 0: finished wins.
        serve(T_CYC, 1'b0, 1'b0, 1'b0, -1, -1);
        check("simultaneous timeout_err", 32'(timeout_err), 32'd0);

        // Pattern 1 never finishes: timeout forces the advance to pattern 2.
        serve(NEVER, 1'b0, 1'b0, 1'b0, -1, -1);
        check("timeout timeout_err", 32'(timeout_err), 32'd1);
        check("timeout active_idx",  32'(active_idx),  32'd2);

        // Stale finished for pattern 0 during its own launch cycle.
        serve(5 * CPM, 1'b0, 1'b0, 1'b1, -1, -1);
        // Spurious finished_in[2] while pattern 0 runs.
        serve(5 * CPM, 1'b0, 1'b1, 1'b0, -1, -1);

        // Randomized runs: finish offsets span early, boundary and timeout.
        for (int i = 0; i < 12; i++) begin
            serve(int'($urandom_range(0, T_CYC + 5)), 1'b1, 1'b0, 1'b0, -1, -1);
        end
        pattern_lights = {8'h33, 8'h22, 8'h11};

        // Drop enable while pattern 1 runs: it completes, then the sequencer idles.
        guard = 0;
        while (m_idx != 1 && guard < N) begin
            serve(8, 1'b0, 1'b0, 1'b0, -1, -1);
            guard++;
        end
        serve(5 * CPM, 1'b0, 1'b0, 1'b0, 10, -1);
        check("drop active_idx", 32'(active_idx), 32'd2);
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("drop idle");
        end
        start_run();

        // Reset in the middle of pattern 2.
        serve(5 * CPM, 1'b0, 1'b0, 1'b0, -1, 10);
        for (int i = 0; i < 10; i++) begin
            step();
            check_idle("post-reset idle");
            check("post-reset pattern_count", 32'(pattern_count), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
